// File: rtl/approx_mult_pkg.sv
// Shared widths, defaults, run states and the |a-b| helper for the
// approximate-multiplier error monitor.
package approx_mult_pkg;

    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int DIFF_W    = PROD_W + 1;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y);
        logic [PROD_W-1:0] r;
        if (x >= y) begin
            r = x - y;
        end else begin
            r = y - x;
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_err_pipe.sv
// Two-stage error pipeline: S1 captures approx and the exact product,
// S2 produces signed diff, error distance and mismatch flag.
module approx_err_pipe
    import approx_mult_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_fire,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_approx,
    output logic              s1_valid,
    output logic              s2_valid,
    output logic [DIFF_W-1:0] s2_diff,
    output logic [PROD_W-1:0] s2_ed,
    output logic              s2_mismatch
);

    logic              s1_valid_r;
    logic [PROD_W-1:0] s1_approx_r;
    logic [PROD_W-1:0] s1_exact_r;
    logic              s2_valid_r;
    logic [DIFF_W-1:0] s2_diff_r;
    logic [PROD_W-1:0] s2_ed_r;
    logic              s2_mismatch_r;

    // Stage 1: capture the accepted triple and the exact product
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_r  <= 1'b0;
            s1_approx_r <= '0;
            s1_exact_r  <= '0;
        end else begin
            s1_valid_r <= in_fire;
            if (in_fire) begin
                s1_approx_r <= in_approx;
                s1_exact_r  <= PROD_W'(in_a) * PROD_W'(in_b);
            end
        end
    end

    // Stage 2: signed error, its magnitude and the mismatch flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s2_valid_r    <= 1'b0;
            s2_diff_r     <= '0;
            s2_ed_r       <= '0;
            s2_mismatch_r <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_diff_r     <= {1'b0, s1_approx_r} - {1'b0, s1_exact_r};
                s2_ed_r       <= abs_diff(s1_approx_r, s1_exact_r);
                s2_mismatch_r <= (s1_approx_r != s1_exact_r);
            end
        end
    end

    assign s1_valid    = s1_valid_r;
    assign s2_valid    = s2_valid_r;
    assign s2_diff     = s2_diff_r;
    assign s2_ed       = s2_ed_r;
    assign s2_mismatch = s2_mismatch_r;

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Run-based error statistics for an 8x8 approximate multiplier: FSM,
// sample counter and saturating accumulators around approx_err_pipe.
module approx_mult_error_monitor
    import approx_mult_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [PROD_W-1:0] in_approx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [ACC_W-1:0]  sum_err,
    output logic [PROD_W-1:0] max_ed,
    output logic              sat
);

    mon_state_t        state_r, state_nx_s;
    logic              in_ready_r, busy_r, done_r, sat_r;
    logic [CNT_W-1:0]  num_lat_r, acc_cnt_r, err_count_r;
    logic [ACC_W-1:0]  sum_ed_r, sum_err_r;
    logic [PROD_W-1:0] max_ed_r;
    logic              fire_s, last_s, clr_s;
    logic              s1_valid_s, s2_valid_s, s2_mismatch_s;
    logic [DIFF_W-1:0] s2_diff_s;
    logic [PROD_W-1:0] s2_ed_s;
    logic [ACC_W:0]    diff_ext_s, sum_ed_ext_s, sum_err_ext_s;
    logic [ACC_W-1:0]  sum_ed_nx_s, sum_err_nx_s;
    logic              ed_ovf_s, err_ovf_s;

    assign fire_s = in_valid & in_ready_r;
    assign last_s = ((acc_cnt_r + CNT_W'(1)) == num_lat_r);

    approx_err_pipe u_pipe (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_fire     (fire_s),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_approx   (in_approx),
        .s1_valid    (s1_valid_s),
        .s2_valid    (s2_valid_s),
        .s2_diff     (s2_diff_s),
        .s2_ed       (s2_ed_s),
        .s2_mismatch (s2_mismatch_s)
    );

    // Next-state decode; the final sample leaves S2 when S1 is already empty
    always_comb begin
        state_nx_s = state_r;
        clr_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_s = 1'b1;
                    if (num_samples != '0) begin
                        state_nx_s = ST_RUN;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (fire_s && last_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (s2_valid_s && !s1_valid_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register with status outputs decoded from the next state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            in_ready_r <= (state_nx_s == ST_RUN);
            busy_r     <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DRAIN);
            done_r     <= (state_nx_s == ST_DONE);
        end
    end

    // Saturating sums: one extra bit exposes the carry / signed overflow
    always_comb begin
        diff_ext_s    = (ACC_W+1)'(signed'(s2_diff_s));
        sum_ed_ext_s  = {1'b0, sum_ed_r} + (ACC_W+1)'(s2_ed_s);
        sum_err_ext_s = {sum_err_r[ACC_W-1], sum_err_r} + diff_ext_s;
        ed_ovf_s      = sum_ed_ext_s[ACC_W];
        err_ovf_s     = sum_err_ext_s[ACC_W] ^ sum_err_ext_s[ACC_W-1];
        if (ed_ovf_s) begin
            sum_ed_nx_s = {ACC_W{1'b1}};
        end else begin
            sum_ed_nx_s = sum_ed_ext_s[ACC_W-1:0];
        end
        if (!err_ovf_s) begin
            sum_err_nx_s = sum_err_ext_s[ACC_W-1:0];
        end else if (sum_err_ext_s[ACC_W]) begin
            sum_err_nx_s = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_err_nx_s = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Run counters and statistics; an honoured start clears the previous run
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            num_lat_r   <= '0;
            acc_cnt_r   <= '0;
            err_count_r <= '0;
            sum_ed_r    <= '0;
            sum_err_r   <= '0;
            max_ed_r    <= '0;
            sat_r       <= 1'b0;
        end else if (clr_s) begin
            num_lat_r   <= num_samples;
            acc_cnt_r   <= '0;
            err_count_r <= '0;
            sum_ed_r    <= '0;
            sum_err_r   <= '0;
            max_ed_r    <= '0;
            sat_r       <= 1'b0;
        end else begin
            if (fire_s) begin
                acc_cnt_r <= acc_cnt_r + CNT_W'(1);
            end
            if (s2_valid_s) begin
                err_count_r <= err_count_r + CNT_W'(s2_mismatch_s);
                sum_ed_r    <= sum_ed_nx_s;
                sum_err_r   <= sum_err_nx_s;
                sat_r       <= sat_r | ed_ovf_s | err_ovf_s;
                if (s2_ed_s > max_ed_r) begin
                    max_ed_r <= s2_ed_s;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_count = err_count_r;
    assign sum_ed    = sum_ed_r;
    assign sum_err   = sum_err_r;
    assign max_ed    = max_ed_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Scoreboard bench: a 32-bit and a 17-bit accumulator instance see the same
// stimulus; expected run statistics are queued at drive time, popped at done.
module tb_approx_mult_error_monitor;

    typedef struct {
        longint cnt;
        longint sed;
        longint serr;
        longint med;
        longint sat;
    } stats_t;

    logic        CLK, RST_N, start, in_valid;
    logic [15:0] num_samples;
    logic [7:0]  in_a, in_b;
    logic [15:0] in_approx;

    logic        in_ready, busy, done, sat;
    logic [15:0] err_count, max_ed;
    logic [31:0] sum_ed, sum_err;

    logic        rdy17, busy17, done17, sat17;
    logic [15:0] ec17, med17;
    logic [16:0] sed17, serr17;

    int n_pass  = 0;
    int n_total = 0;

    bit [7:0]  sa[$];
    bit [7:0]  sb[$];
    bit [15:0] sp[$];
    stats_t    exp32_q[$];
    stats_t    exp17_q[$];

    approx_mult_error_monitor dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy), .done(done), .err_count(err_count),
        .sum_ed(sum_ed), .sum_err(sum_err), .max_ed(max_ed), .sat(sat)
    );

    approx_mult_error_monitor #(.CNT_W(16), .ACC_W(17)) dut17 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(rdy17), .in_a(in_a), .in_b(in_b),
        .in_approx(in_approx), .busy(busy17), .done(done17), .err_count(ec17),
        .sum_ed(sed17), .sum_err(serr17), .max_ed(med17), .sat(sat17)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic stats_t model_step(stats_t m, bit [7:0] a, bit [7:0] b,
                                          bit [15:0] ap, int accw);
        longint ex, d, ed, smax, emax, emin;
        ex   = longint'(a) * longint'(b);
        d    = longint'(ap) - ex;
        ed   = (d < 0) ? -d : d;
        smax = (longint'(1) << accw) - 1;
        emax = (longint'(1) << (accw - 1)) - 1;
        emin = -(longint'(1) << (accw - 1));
        if (d != 0) m.cnt++;
        m.sed += ed;
        if (m.sed > smax) begin m.sed = smax; m.sat = 1; end
        m.serr += d;
        if (m.serr > emax) begin m.serr = emax; m.sat = 1; end
        if (m.serr < emin) begin m.serr = emin; m.sat = 1; end
        if (ed > m.med) m.med = ed;
        return m;
    endfunction

    task automatic add_s(input bit [7:0] a, input bit [7:0] b, input bit [15:0] p);
        sa.push_back(a); sb.push_back(b); sp.push_back(p);
    endtask

    task automatic clear_s();
        sa.delete(); sb.delete(); sp.delete();
    endtask

    task automatic cmp_stats(input string tag);
        stats_t e32, e17;
        if (exp32_q.size() == 0 || exp17_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 0, 1);
        end else begin
            e32 = exp32_q.pop_front();
            e17 = exp17_q.pop_front();
            chk({tag, "_err_count"}, longint'(err_count), e32.cnt);
            chk({tag, "_sum_ed"},    longint'(sum_ed), e32.sed);
            chk({tag, "_sum_err"},   longint'(signed'(sum_err)), e32.serr);
            chk({tag, "_max_ed"},    longint'(max_ed), e32.med);
            chk({tag, "_sat"},       longint'(sat), e32.sat);
            chk({tag, "_done17"},    longint'(done17), 1);
            chk({tag, "_err_count17"}, longint'(ec17), e17.cnt);
            chk({tag, "_sum_ed17"},  longint'(sed17), e17.sed);
            chk({tag, "_sum_err17"}, longint'(signed'(serr17)), e17.serr);
            chk({tag, "_max_ed17"},  longint'(med17), e17.med);
            chk({tag, "_sat17"},     longint'(sat17), e17.sat);
        end
    endtask

    // One complete run over the queued samples; options add idle gaps,
    // a stray start during RUN, or in_valid held high after the last transfer.
    task automatic do_run(input string tag, input bit gaps, input bit poke_start,
                          input bit hold_valid);
        int n;
        int lat;
        int budget;
        bit xfer;
        stats_t m32, m17;
        n   = sa.size();
        m32 = '{0, 0, 0, 0, 0};
        m17 = '{0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            m32 = model_step(m32, sa[i], sb[i], sp[i], 32);
            m17 = model_step(m17, sa[i], sb[i], sp[i], 17);
        end
        exp32_q.push_back(m32);
        exp17_q.push_back(m17);

        num_samples = 16'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, longint'(busy), (n != 0) ? 1 : 0);

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid  = 1'b1;
            in_a      = sa[i];
            in_b      = sb[i];
            in_approx = sp[i];
            if (poke_start && i == 1) begin
                start       = 1'b1;
                num_samples = 16'd7;
            end
            xfer   = 1'b0;
            budget = 0;
            while (!xfer && budget < 20) begin
                xfer = in_ready;
                tick();
                start = 1'b0;
                budget++;
            end
            if (!xfer) chk({tag, "_xfer_timeout"}, 0, 1);
        end

        if (n != 0) begin
            if (!hold_valid) in_valid = 1'b0;
            chk({tag, "_ready_drop"}, longint'(in_ready), 0);
        end
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_done_lat"}, lat, (n != 0) ? 2 : 0);
        chk({tag, "_ready_done"}, longint'(in_ready), 0);
        in_valid = 1'b0;
        cmp_stats(tag);
        chk({tag, "_busy_done"}, longint'(busy), 0);
    endtask

    initial begin
        bit seen_done;
        bit [7:0] ra, rb;
        RST_N       = 1'b0;
        start       = 1'b0;
        num_samples = 16'd0;
        in_valid    = 1'b1;
        in_a        = 8'd9;
        in_b        = 8'd9;
        in_approx   = 16'd1;

        // reset with in_valid asserted
        repeat (2) tick();
        chk("rst_in_ready",  longint'(in_ready), 0);
        chk("rst_busy",      longint'(busy), 0);
        chk("rst_done",      longint'(done), 0);
        chk("rst_err_count", longint'(err_count), 0);
        chk("rst_sum_ed",    longint'(sum_ed), 0);
        chk("rst_sum_err",   longint'(sum_err), 0);
        chk("rst_max_ed",    longint'(max_ed), 0);
        chk("rst_sat",       longint'(sat), 0);
        RST_N    = 1'b1;
        in_valid = 1'b0;
        tick();

        // single sample
        clear_s();
        add_s(8'd200, 8'd150, 16'd29990);
        do_run("single", 1'b0, 1'b0, 1'b0);

        // streaming, with a fifth valid offered after the run closes
        clear_s();
        add_s(8'd255, 8'd255, 16'd65025);
        add_s(8'd3,   8'd5,   16'd0);
        add_s(8'd128, 8'd2,   16'd256);
        add_s(8'd255, 8'd255, 16'd64960);
        do_run("stream", 1'b0, 1'b0, 1'b1);

        // empty run, then restart from DONE
        clear_s();
        do_run("empty", 1'b0, 1'b0, 1'b0);
        clear_s();
        add_s(8'd17, 8'd19, 16'd300);
        add_s(8'd0,  8'd77, 16'd5);
        do_run("restart", 1'b0, 1'b0, 1'b0);

        // saturation (visible on the 17-bit instance)
        clear_s();
        repeat (3) add_s(8'd255, 8'd255, 16'd0);
        do_run("satur", 1'b0, 1'b0, 1'b0);

        // stray start mid-run, and the stream with idle gaps
        clear_s();
        add_s(8'd255, 8'd255, 16'd65025);
        add_s(8'd3,   8'd5,   16'd0);
        add_s(8'd128, 8'd2,   16'd256);
        add_s(8'd255, 8'd255, 16'd64960);
        do_run("poke", 1'b0, 1'b1, 1'b0);
        do_run("gaps", 1'b1, 1'b0, 1'b0);

        // random mixture
        clear_s();
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            add_s(ra, rb, (16'(ra) * 16'(rb)) ^ 16'($urandom_range(0, 3) << 4));
        end
        do_run("rand", 1'b1, 1'b0, 1'b0);

        // reset while draining discards the run
        num_samples = 16'd1;
        start       = 1'b1;
        tick();
        start     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'd10;
        in_b      = 8'd10;
        in_approx = 16'd1;
        tick();
        in_valid = 1'b0;
        chk("drain_busy", longint'(busy), 1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            tick();
            seen_done |= done;
        end
        chk("drrst_done_seen", longint'(seen_done), 0);
        chk("drrst_busy",      longint'(busy), 0);
        chk("drrst_err_count", longint'(err_count), 0);
        chk("drrst_sum_ed",    longint'(sum_ed), 0);
        chk("drrst_sum_err",   longint'(sum_err), 0);
        chk("drrst_max_ed",    longint'(max_ed), 0);
        chk("drrst_ready",     longint'(in_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
